// File: rtl/router_port_tx.sv
// router_port_tx: serializes one packet command (address, byte count, byte
// stream) into the router's frame_n / valid_n / din serial format.
// Frame layout: 4 address bits (LSB first), PAD_CYCLES pad bits, then the
// payload LSB first. frame_n rises on the last payload bit and is followed
// by GAP_CYCLES idle cycles.
module router_port_tx #(
  parameter int PAD_CYCLES = 5,
  parameter int GAP_CYCLES = 1,
  parameter int LEN_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [7:0]       data_byte,
  input  logic             busy_n,
  output logic             frame_n,
  output logic             valid_n,
  output logic             din
);

  // Shared phase counter covers the address, pad and gap phases.
  localparam int CNT_M1  = (PAD_CYCLES > 4) ? PAD_CYCLES : 4;
  localparam int CNT_MAX = (GAP_CYCLES > CNT_M1) ? GAP_CYCLES : CNT_M1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(4);
  localparam logic [CNT_W-1:0] PAD_LAST  = CNT_W'(PAD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_PAD,
    S_DATA,
    S_GAP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       addr_q;
  logic [LEN_W:0]   len_q;
  logic [LEN_W:0]   bytes_loaded;
  logic [LEN_W:0]   bytes_sent;
  logic [7:0]       shreg;
  logic             have_byte;
  logic [2:0]       bit_idx;

  logic             cmd_fire;
  logic             data_fire;
  logic             last_byte;
  logic [LEN_W:0]   len_ext;
  logic [2:0]       bit_nxt;

  // Handshake readiness, derived from registered state only (plus busy_n).
  // A byte may be loaded while the buffer is empty, or during the cycle its
  // bit 7 is on the wire so consecutive bytes run back to back.
  always_comb begin
    cmd_ready  = (state == S_IDLE) && busy_n;
    data_ready = ((state == S_PAD) || (state == S_DATA)) &&
                 (bytes_loaded < len_q) &&
                 (!have_byte || ((state == S_DATA) && (bit_idx == 3'd7)));
  end

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign data_fire = data_valid && data_ready;
  // A zero length field encodes 2^LEN_W bytes.
  assign len_ext   = (cmd_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cmd_len};
  // bytes_sent counts bytes whose bit 0 has gone out, so it includes the
  // byte currently on the wire.
  assign last_byte = (bytes_sent == len_q);
  assign bit_nxt   = bit_idx + 3'd1;

  // Packet sequencer; outputs are registered alongside the state so each
  // transition drives the first output value of the phase being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      bytes_loaded <= '0;
      bytes_sent   <= '0;
      shreg        <= '0;
      have_byte    <= 1'b0;
      bit_idx      <= '0;
      frame_n      <= 1'b1;
      valid_n      <= 1'b1;
      din          <= 1'b0;
    end else begin
      if (data_fire) bytes_loaded <= bytes_loaded + 1'b1;
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            state        <= S_ADDR;
            addr_q       <= cmd_addr;
            len_q        <= len_ext;
            bytes_loaded <= '0;
            bytes_sent   <= '0;
            have_byte    <= 1'b0;
            cnt          <= CNT_W'(1);
            frame_n      <= 1'b0;
            valid_n      <= 1'b1;
            din          <= cmd_addr[0];
          end
        end
        S_ADDR: begin
          if (cnt == ADDR_LAST) begin
            if (PAD_CYCLES == 0) begin
              // No pad phase means no chance to load a byte yet: the first
              // data cycle is an underrun.
              state   <= S_DATA;
              valid_n <= 1'b1;
              din     <= 1'b0;
            end else begin
              state <= S_PAD;
              cnt   <= CNT_W'(1);
              din   <= 1'b1;
            end
          end else begin
            din <= addr_q[cnt[1:0]];
            cnt <= cnt + 1'b1;
          end
        end
        S_PAD: begin
          if (data_fire) begin
            shreg     <= data_byte;
            have_byte <= 1'b1;
          end
          if (cnt == PAD_LAST) begin
            state <= S_DATA;
            if (have_byte || data_fire) begin
              bit_idx    <= 3'd0;
              bytes_sent <= bytes_sent + 1'b1;
              valid_n    <= 1'b0;
              din        <= have_byte ? shreg[0] : data_byte[0];
            end else begin
              valid_n <= 1'b1;
              din     <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (have_byte && (bit_idx != 3'd7)) begin
            bit_idx <= bit_nxt;
            din     <= shreg[bit_nxt];
            valid_n <= 1'b0;
            frame_n <= (bit_idx == 3'd6) && last_byte;
          end else if (have_byte && last_byte) begin
            state     <= S_GAP;
            cnt       <= CNT_W'(1);
            have_byte <= 1'b0;
            frame_n   <= 1'b1;
            valid_n   <= 1'b1;
            din       <= 1'b0;
          end else if (data_fire) begin
            shreg      <= data_byte;
            have_byte  <= 1'b1;
            bit_idx    <= 3'd0;
            bytes_sent <= bytes_sent + 1'b1;
            frame_n    <= 1'b0;
            valid_n    <= 1'b0;
            din        <= data_byte[0];
          end else begin
            // Underrun: hold the frame open with no valid bit.
            have_byte <= 1'b0;
            frame_n   <= 1'b0;
            valid_n   <= 1'b1;
            din       <= 1'b0;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) state <= S_IDLE;
          else                 cnt   <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_port_tx.sv
// tb_router_port_tx: directed and randomized packets; each observed frame is
// decoded back into address, payload bytes and underrun cycles and compared
// with what the bench asked for.
module tb_router_port_tx;

  localparam int PAD = 5;
  localparam int HDR = 4 + PAD;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_len;
  logic       data_valid;
  logic       data_ready;
  logic [7:0] data_byte;
  logic       busy_n;
  logic       frame_n;
  logic       valid_n;
  logic       din;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];

  router_port_tx #(.PAD_CYCLES(PAD), .GAP_CYCLES(1), .LEN_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data_byte  (data_byte),
    .busy_n     (busy_n),
    .frame_n    (frame_n),
    .valid_n    (valid_n),
    .din        (din)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard stop if something hangs despite the bounded loops.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Send one packet whose payload is exp_q, record the frame and decode it.
  task automatic run_packet(input logic [3:0] a, input int n, input int stall_pct,
                            input int hold, input int busy_cyc);
    logic [2:0] fq[$];
    logic [7:0] dq[$];
    logic       bits[$];
    logic [2:0] e;
    logic [3:0] addr_got;
    logic [7:0] b;
    int  acc_idx, first_idx, ready_cnt, busy_bad, held, cyc, budget;
    int  ul, underruns, first_ur, data_bad, hdr_bad, byte_bad, wave_bad, d, j, k;
    bit  acc, done, started, withhold;

    dq = exp_q;
    acc = 0; done = 0; started = 0; acc_idx = -1; first_idx = -1;
    ready_cnt = 0; busy_bad = 0; held = 0; cyc = 0;
    budget = 200 + 40 * n;
    cmd_addr = a;
    cmd_len  = n[7:0];
    while (!done && cyc < budget) begin
      @(negedge clk);
      if (started || !frame_n) begin
        if (!started) first_idx = cyc;
        started = 1;
        fq.push_back({frame_n, valid_n, din});
        if (frame_n && !valid_n) done = 1;
      end
      if (data_ready) ready_cnt++;
      withhold = (hold > 0) && (dq.size() == n - 1) && (held < hold);
      if (withhold && data_ready) held++;
      busy_n     = (cyc >= busy_cyc);
      cmd_valid  = !acc;
      data_valid = (dq.size() > 0) && !withhold && ($urandom_range(99) >= stall_pct);
      if (dq.size() > 0) data_byte = dq[0];
      else               data_byte = 8'h00;
      #1;
      if (cmd_valid && cmd_ready) begin
        acc = 1;
        acc_idx = cyc;
      end
      if (data_valid && data_ready) void'(dq.pop_front());
      if (!busy_n && (cmd_ready || !frame_n)) busy_bad++;
      cyc++;
    end
    cmd_valid  = 0;
    data_valid = 0;

    check_val("frame_done", 32'(done), 32'd1);
    if (busy_cyc > 0) check_val("busy_hold", busy_bad, 0);
    if (done) begin
      check_val("start_latency", first_idx - acc_idx, 1);
      ul = fq.size();
      hdr_bad = 0;
      addr_got = '0;
      for (int i = 0; i < HDR && i < ul; i++) begin
        if (i < 4) begin
          addr_got[i[1:0]] = fq[i][0];
          if (fq[i][2:1] != 2'b01) hdr_bad++;
        end else if (fq[i] != 3'b011) hdr_bad++;
      end
      check_val("addr", 32'(addr_got), 32'(a));
      check_val("hdr_pad", hdr_bad, 0);

      underruns = 0; first_ur = -1; data_bad = 0;
      for (int i = HDR; i < ul; i++) begin
        if (!fq[i][1]) begin
          bits.push_back(fq[i][0]);
          if (fq[i][2] != (i == ul - 1)) data_bad++;
        end else begin
          if (first_ur < 0) first_ur = i;
          underruns++;
          if (fq[i] != 3'b010) data_bad++;
        end
      end
      check_val("data_framing", data_bad, 0);
      check_val("bit_count", bits.size(), 8 * n);
      byte_bad = 0;
      if (bits.size() == 8 * n) begin
        for (int jj = 0; jj < n; jj++) begin
          for (int kk = 0; kk < 8; kk++) b[kk] = bits[8 * jj + kk];
          if (b != exp_q[jj]) byte_bad++;
        end
      end
      check_val("payload", byte_bad, 0);

      if (stall_pct == 0 && hold == 0) begin
        check_val("underruns", underruns, 0);
        check_val("frame_len", ul, HDR + 8 * n);
        check_val("ready_pulses", ready_cnt, n);
        wave_bad = 0;
        for (int i = 0; i < ul; i++) begin
          if (i < 4) e = {1'b0, 1'b1, a[i[1:0]]};
          else if (i < HDR) e = 3'b011;
          else begin
            d = i - HDR; j = d / 8; k = d % 8;
            if (j < n) e = {(j == n - 1) && (k == 7), 1'b0, exp_q[j][k[2:0]]};
            else       e = 3'b111;
          end
          if (fq[i] != e) wave_bad++;
        end
        check_val("wave", wave_bad, 0);
      end
      if (hold > 0) begin
        check_val("hold_underruns", underruns, hold);
        check_val("hold_position", first_ur, HDR + 8);
      end

      @(negedge clk);
      #1;
      check_val("gap_out", 32'({frame_n, valid_n, din}), 32'b110);
      check_val("gap_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      #1;
      check_val("cmd_ready_back", 32'(cmd_ready), 32'd1);
    end
  endtask

  // Start a packet, then assert reset while its 3rd data bit is on the wire.
  task automatic reset_mid_packet();
    int nbits, cyc;
    nbits = 0; cyc = 0;
    busy_n = 1; cmd_addr = 4'h5; cmd_len = 8'd2;
    cmd_valid = 1; data_valid = 1; data_byte = 8'h3C;
    while (nbits < 3 && cyc < 100) begin
      @(negedge clk);
      if (!frame_n) cmd_valid = 0;
      if (!valid_n) nbits++;
      cyc++;
    end
    check_val("reach_bit3", nbits, 3);
    check_val("pre_reset_frame", 32'(frame_n), 32'd0);
    reset = 1;
    #1;
    check_val("reset_async_out", 32'({frame_n, valid_n, din}), 32'b110);
    check_val("reset_data_ready", 32'(data_ready), 32'd0);
    cmd_valid = 0;
    data_valid = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    int n;
    reset = 1; cmd_valid = 0; cmd_addr = '0; cmd_len = '0;
    data_valid = 0; data_byte = '0; busy_n = 0;
    #1;
    check_val("rst_frame_n", 32'(frame_n), 32'd1);
    check_val("rst_valid_n", 32'(valid_n), 32'd1);
    check_val("rst_din", 32'(din), 32'd0);
    check_val("rst_data_ready", 32'(data_ready), 32'd0);
    check_val("rst_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    busy_n = 1;
    #1;
    check_val("rst_cmd_ready_free", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    check_val("idle_out", 32'({frame_n, valid_n, din}), 32'b110);

    exp_q = '{8'hA5};
    run_packet(4'hA, 1, 0, 0, 0);

    exp_q = '{8'hFF, 8'h00};
    run_packet(4'h3, 2, 0, 0, 0);

    exp_q = '{8'h5A, 8'hC3};
    run_packet(4'h6, 2, 0, 3, 0);

    exp_q = '{8'h81};
    run_packet(4'h9, 1, 0, 0, 5);

    reset_mid_packet();
    exp_q = '{8'h4E};
    run_packet(4'hC, 1, 0, 0, 0);

    for (int p = 0; p < 10; p++) begin
      n = $urandom_range(1, 6);
      exp_q.delete();
      for (int q = 0; q < n; q++) exp_q.push_back(8'($urandom));
      run_packet(4'($urandom), n, $urandom_range(0, 60), 0, 0);
    end

    exp_q.delete();
    for (int q = 0; q < 256; q++) exp_q.push_back(8'($urandom));
    run_packet(4'hF, 256, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/router_port_tx.md
# router_port_tx

Serializing packet transmitter for one router input port: accepts a destination address, a byte count and a byte stream, and drives that port's `frame_n`/`valid_n`/`din` with the router's serial packet format. One instance sits in front of each router input; it replaces hand-written bench stimulus with a synthesizable source usable by both integration and tests.

## Interface
- `PAD_CYCLES`, 5: pad cycles between the last address bit and the first data bit.
- `GAP_CYCLES`, 1: minimum idle cycles with `frame_n` high between packets; must be ≥1.
- `LEN_W`, 8: width of `cmd_len`.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  packet command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_addr`  in  4  destination output port.
- `cmd_len`  in  LEN_W  payload byte count; 0 means 2^LEN_W bytes.
- `data_valid`  in  1  payload byte offered.
- `data_ready`  out  1  byte accepted when `data_valid && data_ready` at a rising edge.
- `data_byte`  in  8  payload byte, sent LSB first.
- `busy_n`  in  1  router busy indication for this port; low = busy.
- `frame_n`  out  1  frame, active low, registered.
- `valid_n`  out  1  payload bit valid, active low, registered.
- `din`  out  1  serial data, registered.

## Operation
- States: IDLE, ADDR, PAD, DATA, GAP.
- IDLE: `cmd_ready = busy_n`. `busy_n` is sampled only here; it is ignored once a packet starts. On accept: latch addr and len, go to ADDR.
- ADDR: 4 cycles; `frame_n`=0, `valid_n`=1, `din`=addr[0..3] LSB first.
- PAD: PAD_CYCLES cycles; `frame_n`=0, `valid_n`=1, `din`=1.
- DATA: each cycle with a loaded byte, `valid_n`=0 and `din`=shreg[bit_idx], bit_idx 0→7. With no byte loaded (underrun): `valid_n`=1, `din`=0, `frame_n` stays 0.
- Last bit of last byte: `frame_n`=1 and `valid_n`=0 on the same cycle. Then go to GAP.
- GAP: GAP_CYCLES cycles; `frame_n`=1, `valid_n`=1, `din`=0. Then go to IDLE.
- Byte buffer: 8-bit shift register plus a `have_byte` flag.
  - `data_ready` = (state is PAD or DATA) && bytes_loaded < len && (!have_byte || (DATA && bit_idx==7)).
  - Loading on the cycle bit 7 leaves gives back-to-back bytes with no `valid_n` gap.
- Counters: bytes_loaded and bytes_sent are LEN_W+1 bits wide, so 2^LEN_W bytes is representable. A PAD/ADDR counter sized for max(4, PAD_CYCLES, GAP_CYCLES).
- PAD_CYCLES=0 is legal: DATA follows ADDR directly, and the first data bit may be an underrun gap.

## Timing
- Reset (async, immediate) values: state IDLE, `frame_n`=1, `valid_n`=1, `din`=0, `have_byte`=0, counters 0. `cmd_ready` follows `busy_n`; `data_ready`=0.
- Reset mid-packet: outputs return to idle values immediately and the packet is abandoned. The next command after reset release starts a fresh frame.
- Command accepted at edge T:
  - Addr bits on cycles T+1..T+4.
  - Pad on T+5..T+4+PAD_CYCLES.
  - First data bit at T+5+PAD_CYCLES, if a byte was accepted during PAD.
- An N-byte packet with no underrun occupies 4+PAD_CYCLES+8N cycles with `frame_n` low.
- `cmd_ready` rises at the end of the last GAP cycle.
- With defaults, the next frame starts no earlier than 2 cycles after `frame_n` rises.
- Outputs change only on rising `clk` edges or on `reset`.

## Test plan
- Reset then idle → `frame_n`=1, `valid_n`=1, `din`=0, `data_ready`=0, `cmd_ready`=`busy_n`.
- addr=4'hA, len=1, byte 8'hA5, defaults, accept at T →
  - `din` 0,1,0,1 on T+1..T+4.
  - `din`=1 with `valid_n`=1 on T+5..T+9.
  - `din` 1,0,1,0,0,1,0,1 with `valid_n`=0 on T+10..T+17.
  - `frame_n`=1 at T+17; `cmd_ready` high at T+19.
- addr=3, len=2, bytes 8'hFF then 8'h00 both offered early → 16 contiguous `valid_n`=0 cycles, `frame_n` rises on the 16th; `data_ready` pulses exactly twice.
- len=2, second byte withheld 3 cycles after the first byte's bit 7 → `valid_n`=1 and `frame_n`=0 for 3 cycles, then 8 bits of the second byte.
- `busy_n`=0 with `cmd_valid`=1 for 5 cycles, then `busy_n`=1 → no accept and no frame while busy; `frame_n` falls one cycle after the accepting edge.
- Reset asserted at the 3rd data bit → `frame_n`/`valid_n`/`din` go to 1/1/0 before the next edge. A new len=1 packet then completes correctly.
